// File: rtl/acc_stream_ctrl_pkg.sv
// acc_stream_ctrl_pkg
// Shared definitions for the accumulator stream controller:
//   - accumulator command codes driven on cmd / echoed on status
//   - default sizes (N pairs, AW address bits, DW data bits, watchdog limit)
//   - controller state encoding
package acc_stream_ctrl_pkg;

  localparam int N_DEF       = 128;
  localparam int AW_DEF      = 7;
  localparam int DW_DEF      = 16;
  localparam int TIMEOUT_DEF = 1024;

  localparam logic [3:0] CMD_IDLE = 4'd0;
  localparam logic [3:0] CMD_LOAD = 4'd1;
  localparam logic [3:0] CMD_ACC  = 4'd2;
  localparam logic [3:0] CMD_READ = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_STREAM,
    ST_RD_STREAM,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/acc_stream_skid.sv
// acc_stream_skid
// One-entry skid buffer for the {addr, data_a, data_b} pair stream.
// A word arriving while the consumer cannot take it is parked here and is
// presented ahead of any newer word once the consumer frees up.
// Ports:
//   clk, reset    clock, async active-low reset
//   clr           synchronous flush (new transfer)
//   in_valid/pay  word arriving from the source RAM this cycle
//   out_ready     consumer takes out_pay at the next edge
//   out_valid/pay oldest available word (parked word first)
//   held          buffer currently occupied
module acc_stream_skid
  import acc_stream_ctrl_pkg::*;
#(
  parameter int W = AW_DEF + 2 * DW_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_pay,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_pay,
  output logic         held
);

  logic         hold_q;
  logic [W-1:0] hold_pay;

  assign held      = hold_q;
  assign out_valid = hold_q | in_valid;
  assign out_pay   = hold_q ? hold_pay : in_pay;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q   <= 1'b0;
      hold_pay <= '0;
    end else if (clr) begin
      hold_q <= 1'b0;
    end else if (hold_q) begin
      // parked word drains; a word arriving in the same cycle takes its place
      if (out_ready) begin
        hold_q   <= in_valid;
        hold_pay <= in_pay;
      end
    end else if (in_valid && !out_ready) begin
      hold_q   <= 1'b1;
      hold_pay <= in_pay;
    end
  end

endmodule

// File: rtl/acc_stream_ctrl.sv
// acc_stream_ctrl
// Host side of the accumulator command/readin/readout interface.
// Load/accumulate (op 1/2) stream N pairs from a 1-cycle-latency source RAM
// to the accumulator; readback (op 3) drains N results into a sink RAM.
// Optional watchdog: define ACC_STREAM_TIMEOUT_EN to abort after TIMEOUT
// consecutive cycles with status != cmd; otherwise err is tied 0.
// Ports:
//   clk, reset                 clock, async active-low reset
//   start, op                  request (accepted in IDLE, op != 0)
//   busy, done, err            transfer status
//   src_en/addr, src_data_a/b  source RAM read port
//   cmd, readin, readout       accumulator control
//   addr_a/b, data_a/b         pair presented to accumulator
//   status, addr_out, data_*_out  accumulator response
//   dst_we/addr, dst_data_a/b  sink RAM write port
//
// state        | meaning
// ST_IDLE      | waiting for start
// ST_ARM       | cmd driven, waiting for status == cmd
// ST_STREAM    | fetching and presenting pairs (op 1/2)
// ST_RD_STREAM | issuing readout and writing results (op 3)
// ST_FINISH    | cmd back to 0, done pulse
module acc_stream_ctrl
  import acc_stream_ctrl_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          src_en,
  output logic [AW-1:0] src_addr,
  input  logic [DW-1:0] src_data_a,
  input  logic [DW-1:0] src_data_b,
  output logic [3:0]    cmd,
  output logic          readin,
  output logic          readout,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b,
  input  logic [3:0]    status,
  input  logic [AW-1:0] addr_out,
  input  logic [DW-1:0] data_a_out,
  input  logic [DW-1:0] data_b_out,
  output logic          dst_we,
  output logic [AW-1:0] dst_addr,
  output logic [DW-1:0] dst_data_a,
  output logic [DW-1:0] dst_data_b
);

  localparam int              CW     = AW + 1;
  localparam int              PW     = AW + 2 * DW;
  localparam logic [CW-1:0]   N_CNT  = CW'(N);
  localparam logic [CW-1:0]   N_LAST = CW'(N - 1);

  state_t          state, state_nxt;
  logic [1:0]      op_q;
  logic [CW-1:0]   fetch_cnt, pres_cnt, wr_cnt;
  logic            pend_q, out_valid, rvalid_q;
  logic [AW-1:0]   pend_addr;
  logic [PW-1:0]   out_pay, sk_pay;
  logic            sk_valid, sk_held;
  logic            start_acc, status_ok, accept, out_free, room, timeout;
  logic [1:0]      occ;

  assign start_acc = (state == ST_IDLE) && start && (op != 2'd0);
  assign status_ok = (status == {2'b00, op_q});
  assign accept    = (state == ST_STREAM) && out_valid && status_ok;
  assign out_free  = !out_valid || accept;

  // Only fetch when the word returning next cycle is guaranteed a slot
  // (output register or skid) even if the accumulator stalls then.
  assign occ  = {1'b0, out_valid} + {1'b0, sk_held} + {1'b0, pend_q};
  assign room = occ <= (2'd1 + {1'b0, accept});

  acc_stream_skid #(.W(PW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_acc),
    .in_valid  (pend_q),
    .in_pay    ({pend_addr, src_data_a, src_data_b}),
    .out_ready (out_free),
    .out_valid (sk_valid),
    .out_pay   (sk_pay),
    .held      (sk_held)
  );

`ifdef ACC_STREAM_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;
  logic          err_q;
  logic          waiting;

  assign waiting = ((state == ST_ARM) || (state == ST_STREAM) || (state == ST_RD_STREAM))
                   && !status_ok;
  assign timeout = waiting && (wd_cnt == WW'(TIMEOUT - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else if (start_acc) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else if (timeout) begin
      wd_cnt <= '0;
      err_q  <= 1'b1;
    end else if (waiting) begin
      wd_cnt <= wd_cnt + WW'(1);
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start_acc) state_nxt = ST_ARM;
      ST_ARM: begin
        if (timeout)        state_nxt = ST_FINISH;
        else if (status_ok) state_nxt = (op_q == CMD_READ[1:0]) ? ST_RD_STREAM : ST_STREAM;
      end
      ST_STREAM: begin
        if (timeout)                            state_nxt = ST_FINISH;
        else if (accept && pres_cnt == N_LAST)  state_nxt = ST_FINISH;
      end
      ST_RD_STREAM: begin
        if (timeout)                            state_nxt = ST_FINISH;
        else if (rvalid_q && wr_cnt == N_LAST)  state_nxt = ST_FINISH;
      end
      ST_FINISH:    state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    cmd        = CMD_IDLE;
    readin     = 1'b0;
    readout    = 1'b0;
    src_en     = 1'b0;
    src_addr   = '0;
    dst_we     = 1'b0;
    dst_addr   = '0;
    dst_data_a = '0;
    dst_data_b = '0;
    case (state)
      ST_ARM: begin
        busy = 1'b1;
        cmd  = {2'b00, op_q};
      end
      ST_STREAM: begin
        busy     = 1'b1;
        cmd      = {2'b00, op_q};
        readin   = accept;
        src_en   = status_ok && (fetch_cnt != N_CNT) && room;
        src_addr = src_en ? fetch_cnt[AW-1:0] : '0;
      end
      ST_RD_STREAM: begin
        busy    = 1'b1;
        cmd     = {2'b00, op_q};
        readout = status_ok && (fetch_cnt != N_CNT);
        dst_we  = rvalid_q;
        if (rvalid_q) begin
          dst_addr   = addr_out;
          dst_data_a = data_a_out;
          dst_data_b = data_b_out;
        end
      end
      ST_FINISH:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= 2'd0;
      fetch_cnt <= '0;
      pres_cnt  <= '0;
      wr_cnt    <= '0;
      pend_q    <= 1'b0;
      pend_addr <= '0;
      out_valid <= 1'b0;
      out_pay   <= '0;
      rvalid_q  <= 1'b0;
    end else if (start_acc) begin
      op_q      <= op;
      fetch_cnt <= '0;
      pres_cnt  <= '0;
      wr_cnt    <= '0;
      pend_q    <= 1'b0;
      out_valid <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      pend_q <= src_en;
      if (src_en) pend_addr <= fetch_cnt[AW-1:0];
      // fetch counter doubles as readout request counter in readback
      if (src_en || readout) fetch_cnt <= fetch_cnt + CW'(1);
      if (out_free) begin
        out_valid <= sk_valid;
        if (sk_valid) out_pay <= sk_pay;
      end
      if (accept) pres_cnt <= pres_cnt + CW'(1);
      rvalid_q <= readout;
      if (dst_we) wr_cnt <= wr_cnt + CW'(1);
    end
  end

  assign addr_a = out_pay[PW-1 -: AW];
  assign addr_b = out_pay[PW-1 -: AW];
  assign data_a = out_pay[2*DW-1 -: DW];
  assign data_b = out_pay[DW-1:0];

endmodule
